// File: rtl/adpll_lock_sequencer.sv
// ADPLL lock-acquisition sequencer: gates/decimates UP/DN corrections and runs a windowed lock detector.
// Define ADPLL_FAST_RELOCK_EN to relock through FINE instead of COARSE after loss of lock.
module adpll_lock_sequencer #(
  parameter int WIN        = 64,
  parameter int LOCK_THR   = 2,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int FINE_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       UP,
  input  logic       DN,
  output logic       UP_out,
  output logic       DN_out,
  output logic [1:0] state,
  output logic       locked,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int WW = $clog2(WIN);
  localparam int NW = WW + 2;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int DW = (FINE_DIV > 1) ? $clog2(FINE_DIV) : 1;

  localparam logic [WW-1:0]        WIN_LAST  = WW'(WIN - 1);
  localparam logic signed [NW-1:0] THR_POS   = NW'(LOCK_THR);
  localparam logic signed [NW-1:0] THR_NEG   = -THR_POS;
  localparam logic [GW-1:0]        GOOD_DONE = GW'(LOCK_CNT);
  localparam logic [BW-1:0]        BAD_DONE  = BW'(UNLOCK_CNT);
  localparam logic [DW-1:0]        DIV_LAST  = DW'(FINE_DIV - 1);

`ifdef ADPLL_FAST_RELOCK_EN
  localparam state_t RELOCK_ST = ST_FINE;
`else
  localparam state_t RELOCK_ST = ST_COARSE;
`endif

  state_t                state_q, state_d;
  logic [WW-1:0]         win_cnt_q, win_cnt_d;
  logic signed [NW-1:0]  net_q, net_d;
  logic [GW-1:0]         good_cnt_q, good_cnt_d;
  logic [BW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [DW-1:0]         up_div_q, up_div_d;
  logic [DW-1:0]         dn_div_q, dn_div_d;
  logic                  up_out_q, up_out_d;
  logic                  dn_out_q, dn_out_d;
  logic                  locked_q, locked_d;
  logic                  lock_lost_q, lock_lost_d;

  logic                  u, d;
  logic signed [NW-1:0]  net_step;
  logic signed [NW-1:0]  net_sum;
  logic                  win_end;
  logic                  win_good;
  logic [GW-1:0]         good_inc;
  logic [BW-1:0]         bad_inc;

  // Simultaneous UP and DN cancel and count as no event.
  assign u        = UP & ~DN;
  assign d        = DN & ~UP;
  assign net_step = u ? NW'(1) : (d ? {NW{1'b1}} : {NW{1'b0}});
  assign net_sum  = net_q + net_step;
  assign win_end  = (win_cnt_q == WIN_LAST);
  assign win_good = (net_sum <= THR_POS) && (net_sum >= THR_NEG);
  assign good_inc = good_cnt_q + 1'b1;
  assign bad_inc  = bad_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    net_d       = net_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    up_div_d    = up_div_q;
    dn_div_d    = dn_div_q;
    up_out_d    = 1'b0;
    dn_out_d    = 1'b0;
    lock_lost_d = 1'b0;

    if (!enable || (state_q == ST_IDLE)) begin
      state_d    = enable ? ST_COARSE : ST_IDLE;
      win_cnt_d  = '0;
      net_d      = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      up_div_d   = '0;
      dn_div_d   = '0;
    end else begin
      if (state_q == ST_COARSE) begin
        up_out_d = u;
        dn_out_d = d;
      end else begin
        // An opposite-direction event restarts the other side's decimator.
        if (u) begin
          dn_div_d = '0;
          if (up_div_q == DIV_LAST) begin
            up_out_d = 1'b1;
            up_div_d = '0;
          end else begin
            up_div_d = up_div_q + 1'b1;
          end
        end
        if (d) begin
          up_div_d = '0;
          if (dn_div_q == DIV_LAST) begin
            dn_out_d = 1'b1;
            dn_div_d = '0;
          end else begin
            dn_div_d = dn_div_q + 1'b1;
          end
        end
      end

      net_d     = net_sum;
      win_cnt_d = win_cnt_q + 1'b1;

      if (win_end) begin
        net_d     = '0;
        win_cnt_d = '0;
        case (state_q)
          ST_COARSE: begin
            if (win_good) begin
              state_d    = ST_FINE;
              good_cnt_d = '0;
            end
          end
          ST_FINE: begin
            if (win_good) begin
              if (good_inc == GOOD_DONE) begin
                state_d    = ST_LOCKED;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
              end else begin
                good_cnt_d = good_inc;
              end
            end else begin
              state_d    = ST_COARSE;
              good_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            if (win_good) begin
              bad_cnt_d = '0;
            end else if (bad_inc == BAD_DONE) begin
              state_d     = RELOCK_ST;
              lock_lost_d = 1'b1;
              good_cnt_d  = '0;
              bad_cnt_d   = '0;
            end else begin
              bad_cnt_d = bad_inc;
            end
          end
          default: ;
        endcase
      end

      if (state_d != state_q) begin
        up_div_d = '0;
        dn_div_d = '0;
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      net_q       <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      up_div_q    <= '0;
      dn_div_q    <= '0;
      up_out_q    <= 1'b0;
      dn_out_q    <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      net_q       <= net_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      up_div_q    <= up_div_d;
      dn_div_q    <= dn_div_d;
      up_out_q    <= up_out_d;
      dn_out_q    <= dn_out_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign UP_out    = up_out_q;
  assign DN_out    = dn_out_q;
  assign state     = state_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;

endmodule
